activation_sequencer: RTL and testbench

- Controller that runs one activation job over a block of accumulator rows: streams rows out of the accumulator buffer, drives en/sel of the registered activation unit, and writes results to the output buffer.
- Sits between the top-level layer controller (start/done handshake plus job descriptor) and the activation unit and its buffers.
- Carries no data. It only generates addresses, enables, the function select and job status.

---
 rtl/activation_sequencer.sv | 145 ++++++++++++++
 tb/tb_activation_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/activation_sequencer.sv
// Sequences one activation job: streams source rows, drives the activation unit, writes results.
// Latency rd_en -> wr_en is RD_LATENCY+1 cycles; one row per cycle, no backpressure (abort cancels).
module activation_sequencer #(
    parameter int ADDR_WIDTH  = 8,
    parameter int COUNT_WIDTH = 9,
    parameter int RD_LATENCY  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             cfg_sel,
    input  logic [ADDR_WIDTH-1:0]  cfg_src_base,
    input  logic [ADDR_WIDTH-1:0]  cfg_dst_base,
    input  logic [COUNT_WIDTH-1:0] cfg_rows,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic                   act_en,
    output logic [1:0]             act_sel,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [COUNT_WIDTH-1:0] rows_written
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  src_base_q, src_base_d;
    logic [ADDR_WIDTH-1:0]  dst_base_q, dst_base_d;
    logic [COUNT_WIDTH-1:0] rows_q, rows_d;
    logic [1:0]             sel_q, sel_d;
    logic [COUNT_WIDTH-1:0] issued_q, issued_d;
    logic                   rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [RD_LATENCY+1:1]  vld_q, vld_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [1:0]             act_sel_q, act_sel_d;
    logic [COUNT_WIDTH-1:0] rows_written_q, rows_written_d;

    always_comb begin
        state_d        = state_q;
        src_base_d     = src_base_q;
        dst_base_d     = dst_base_q;
        rows_d         = rows_q;
        sel_d          = sel_q;
        issued_d       = issued_q;
        rd_en_d        = 1'b0;
        rd_addr_d      = '0;
        vld_d          = {vld_q[RD_LATENCY:1], rd_en_q};
        rows_written_d = vld_q[RD_LATENCY+1] ? rows_written_q + COUNT_WIDTH'(1) : rows_written_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    src_base_d     = cfg_src_base;
                    dst_base_d     = cfg_dst_base;
                    rows_d         = cfg_rows;
                    sel_d          = cfg_sel;
                    rows_written_d = '0;
                    if (cfg_rows == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d   = S_RUN;
                        rd_en_d   = 1'b1;
                        rd_addr_d = cfg_src_base;
                        issued_d  = COUNT_WIDTH'(1);
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    vld_d   = '0;
                end else if (issued_q == rows_q) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = src_base_q + ADDR_WIDTH'(issued_q);
                    issued_d  = issued_q + COUNT_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                // Finish once the last in-flight row leaves the write tap this cycle.
                if (abort) begin
                    state_d = S_IDLE;
                    vld_d   = '0;
                end else if (vld_d == '0) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d    = (state_d == S_FIN);
        act_sel_d = busy_d ? sel_d : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            src_base_q     <= '0;
            dst_base_q     <= '0;
            rows_q         <= '0;
            sel_q          <= '0;
            issued_q       <= '0;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            vld_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            act_sel_q      <= '0;
            rows_written_q <= '0;
        end else begin
            state_q        <= state_d;
            src_base_q     <= src_base_d;
            dst_base_q     <= dst_base_d;
            rows_q         <= rows_d;
            sel_q          <= sel_d;
            issued_q       <= issued_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            vld_q          <= vld_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            act_sel_q      <= act_sel_d;
            rows_written_q <= rows_written_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign act_en       = vld_q[RD_LATENCY];
    assign act_sel      = act_sel_q;
    assign wr_en        = vld_q[RD_LATENCY+1];
    assign wr_addr      = dst_base_q + ADDR_WIDTH'(rows_written_q);
    assign rows_written = rows_written_q;

endmodule

// File: tb/tb_activation_sequencer.sv
// Directed bench for activation_sequencer at RD_LATENCY=1 and RD_LATENCY=3.
module tb_activation_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, start3, abort;
    logic [1:0] cfg_sel;
    logic [7:0] src, dst;
    logic [8:0] rows;

    logic       busy1, done1, rd1, ae1, we1;
    logic [7:0] ra1, wa1;
    logic [1:0] as1;
    logic [8:0] rw1;
    logic       busy3, done3, rd3, ae3, we3;
    logic [7:0] ra3, wa3;
    logic [1:0] as3;
    logic [8:0] rw3;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    activation_sequencer #(.ADDR_WIDTH(8), .COUNT_WIDTH(9), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_sel(cfg_sel),
        .cfg_src_base(src), .cfg_dst_base(dst), .cfg_rows(rows),
        .busy(busy1), .done(done1), .rd_en(rd1), .rd_addr(ra1), .act_en(ae1),
        .act_sel(as1), .wr_en(we1), .wr_addr(wa1), .rows_written(rw1)
    );

    activation_sequencer #(.ADDR_WIDTH(8), .COUNT_WIDTH(9), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort), .cfg_sel(cfg_sel),
        .cfg_src_base(src), .cfg_dst_base(dst), .cfg_rows(rows),
        .busy(busy3), .done(done3), .rd_en(rd3), .rd_addr(ra3), .act_en(ae3),
        .act_sel(as3), .wr_en(we3), .wr_addr(wa3), .rows_written(rw3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares one cycle of outputs; addresses only matter when their strobe is expected.
    task automatic st(input string tag, input int d, input logic bz, input logic dn,
                      input logic rd, input logic [7:0] ra, input logic ae,
                      input logic [1:0] as, input logic we, input logic [7:0] wa);
        logic [22:0] o, e;
        if (d == 1)
            o = {busy1, done1, rd1, ae1, we1, as1, rd ? ra1 : 8'h00, we ? wa1 : 8'h00};
        else
            o = {busy3, done3, rd3, ae3, we3, as3, rd ? ra3 : 8'h00, we ? wa3 : 8'h00};
        e = {bz, dn, rd, ae, we, as, rd ? ra : 8'h00, we ? wa : 8'h00};
        checks++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic chk_rw(input string tag, input int d, input logic [8:0] exp);
        logic [8:0] o;
        o = (d == 1) ? rw1 : rw3;
        checks++;
        assert (o === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, o, exp);
    endtask

    task automatic launch(input logic [8:0] n, input logic [7:0] s, input logic [7:0] t,
                          input logic [1:0] f);
        rows = n; src = s; dst = t; cfg_sel = f;
        start = 1'b1;
        tick();
        start = 1'b0;
        rows = '0; src = '0; dst = '0; cfg_sel = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start3 = 1'b0; abort = 1'b0;
        cfg_sel = '0; src = '0; dst = '0; rows = '0;
        tick(); tick();
        st("reset_outputs", 1, 0,0, 0,8'h00, 0,2'd0, 0,8'h00);
        chk_rw("reset_rows_written", 1, 9'd0);
        { checks, passed } = { checks, passed };
        checks++;
        assert (wa1 === 8'h00 && ra1 === 8'h00) passed++;
        else $error("FAIL reset_addrs observed=%h/%h expected=00/00", ra1, wa1);
        rst = 1'b0;
        tick();

        // Basic job: rows=3 src=0x10 dst=0x40 sigmoid.
        launch(9'd3, 8'h10, 8'h40, 2'd1);
        st("basic_c1", 1, 1,0, 1,8'h10, 0,2'd1, 0,8'h00); tick();
        st("basic_c2", 1, 1,0, 1,8'h11, 1,2'd1, 0,8'h00); tick();
        st("basic_c3", 1, 1,0, 1,8'h12, 1,2'd1, 1,8'h40); tick();
        st("basic_c4", 1, 1,0, 0,8'h00, 1,2'd1, 1,8'h41); tick();
        st("basic_c5", 1, 1,0, 0,8'h00, 0,2'd1, 1,8'h42); tick();
        st("basic_c6", 1, 0,1, 0,8'h00, 0,2'd0, 0,8'h00); tick();
        st("basic_c7", 1, 0,0, 0,8'h00, 0,2'd0, 0,8'h00);
        chk_rw("basic_rows_written", 1, 9'd3);
        tick();

        // Zero-row job: immediate done, never busy, rows_written cleared.
        launch(9'd0, 8'h33, 8'h44, 2'd2);
        st("zero_c1", 1, 0,1, 0,8'h00, 0,2'd0, 0,8'h00);
        chk_rw("zero_rows_written", 1, 9'd0);
        tick();
        st("zero_c2", 1, 0,0, 0,8'h00, 0,2'd0, 0,8'h00);
        tick();

        // Address wrap on both buffers.
        launch(9'd4, 8'hFE, 8'hFF, 2'd3);
        st("wrap_c1", 1, 1,0, 1,8'hFE, 0,2'd3, 0,8'h00); tick();
        st("wrap_c2", 1, 1,0, 1,8'hFF, 1,2'd3, 0,8'h00); tick();
        st("wrap_c3", 1, 1,0, 1,8'h00, 1,2'd3, 1,8'hFF); tick();
        st("wrap_c4", 1, 1,0, 1,8'h01, 1,2'd3, 1,8'h00); tick();
        st("wrap_c5", 1, 1,0, 0,8'h00, 1,2'd3, 1,8'h01); tick();
        st("wrap_c6", 1, 1,0, 0,8'h00, 0,2'd3, 1,8'h02); tick();
        st("wrap_c7", 1, 0,1, 0,8'h00, 0,2'd0, 0,8'h00);
        chk_rw("wrap_rows_written", 1, 9'd4);
        tick();

        // Abort during the third read.
        launch(9'd5, 8'h20, 8'h50, 2'd2);
        st("abort_c1", 1, 1,0, 1,8'h20, 0,2'd2, 0,8'h00); tick();
        st("abort_c2", 1, 1,0, 1,8'h21, 1,2'd2, 0,8'h00); tick();
        st("abort_c3", 1, 1,0, 1,8'h22, 1,2'd2, 1,8'h50);
        abort = 1'b1; tick(); abort = 1'b0;
        st("abort_c4", 1, 0,0, 0,8'h00, 0,2'd0, 0,8'h00);
        chk_rw("abort_rows_written", 1, 9'd1);
        tick();
        st("abort_c5_nodone", 1, 0,0, 0,8'h00, 0,2'd0, 0,8'h00);
        launch(9'd1, 8'h30, 8'h60, 2'd0);
        st("post_abort_c1", 1, 1,0, 1,8'h30, 0,2'd0, 0,8'h00); tick();
        st("post_abort_c2", 1, 1,0, 0,8'h00, 1,2'd0, 0,8'h00); tick();
        st("post_abort_c3", 1, 1,0, 0,8'h00, 0,2'd0, 1,8'h60); tick();
        st("post_abort_c4", 1, 0,1, 0,8'h00, 0,2'd0, 0,8'h00);
        chk_rw("post_abort_rows_written", 1, 9'd1);
        tick();

        // Abort together with start in IDLE: not accepted.
        abort = 1'b1;
        launch(9'd2, 8'h70, 8'h80, 2'd1);
        abort = 1'b0;
        st("abort_start_c1", 1, 0,0, 0,8'h00, 0,2'd0, 0,8'h00); tick();
        st("abort_start_c2", 1, 0,0, 0,8'h00, 0,2'd0, 0,8'h00);

        // start held high: second job only after FIN.
        rows = 9'd2; src = 8'h00; dst = 8'h08; cfg_sel = 2'd0; start = 1'b1;
        tick();
        st("hold_c1", 1, 1,0, 1,8'h00, 0,2'd0, 0,8'h00); tick();
        st("hold_c2", 1, 1,0, 1,8'h01, 1,2'd0, 0,8'h00); tick();
        st("hold_c3", 1, 1,0, 0,8'h00, 1,2'd0, 1,8'h08); tick();
        st("hold_c4", 1, 1,0, 0,8'h00, 0,2'd0, 1,8'h09); tick();
        st("hold_c5", 1, 0,1, 0,8'h00, 0,2'd0, 0,8'h00); tick();
        st("hold_c6", 1, 0,0, 0,8'h00, 0,2'd0, 0,8'h00); tick();
        st("hold_c7", 1, 1,0, 1,8'h00, 0,2'd0, 0,8'h00);
        chk_rw("hold_rows_cleared", 1, 9'd0);
        start = 1'b0;
        tick(); tick(); tick(); tick();
        st("hold_c11", 1, 0,1, 0,8'h00, 0,2'd0, 0,8'h00);
        tick();

        // Reset in DRAIN: everything drops, no done.
        launch(9'd3, 8'h10, 8'h40, 2'd1);
        tick(); tick(); tick();
        st("rst_c4_drain", 1, 1,0, 0,8'h00, 1,2'd1, 1,8'h41);
        rst = 1'b1; tick(); rst = 1'b0;
        st("rst_c5", 1, 0,0, 0,8'h00, 0,2'd0, 0,8'h00);
        chk_rw("rst_rows_written", 1, 9'd0);
        checks++;
        assert (wa1 === 8'h00) passed++;
        else $error("FAIL rst_wr_addr observed=%h expected=00", wa1);
        tick();
        st("rst_c6_nodone", 1, 0,0, 0,8'h00, 0,2'd0, 0,8'h00); tick();
        st("rst_c7_nodone", 1, 0,0, 0,8'h00, 0,2'd0, 0,8'h00);

        // RD_LATENCY=3 rerun of the basic job.
        rows = 9'd3; src = 8'h10; dst = 8'h40; cfg_sel = 2'd1; start3 = 1'b1;
        tick();
        start3 = 1'b0; rows = '0; src = '0; dst = '0; cfg_sel = '0;
        st("lat3_c1", 3, 1,0, 1,8'h10, 0,2'd1, 0,8'h00); tick();
        st("lat3_c2", 3, 1,0, 1,8'h11, 0,2'd1, 0,8'h00); tick();
        st("lat3_c3", 3, 1,0, 1,8'h12, 0,2'd1, 0,8'h00); tick();
        st("lat3_c4", 3, 1,0, 0,8'h00, 1,2'd1, 0,8'h00); tick();
        st("lat3_c5", 3, 1,0, 0,8'h00, 1,2'd1, 1,8'h40); tick();
        st("lat3_c6", 3, 1,0, 0,8'h00, 1,2'd1, 1,8'h41); tick();
        st("lat3_c7", 3, 1,0, 0,8'h00, 0,2'd1, 1,8'h42); tick();
        st("lat3_c8", 3, 0,1, 0,8'h00, 0,2'd0, 0,8'h00); tick();
        st("lat3_c9", 3, 0,0, 0,8'h00, 0,2'd0, 0,8'h00);
        chk_rw("lat3_rows_written", 3, 9'd3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
